sum_readout: RTL and testbench

Streams the 64-entry, 9-bit sum memory that the image adder fills out to a downstream consumer, one 8-bit pixel per beat. It sits directly after the adder's result memory and drives that memory's read port. On each start pulse it sweeps addresses 0 to 63 and normalises each 9-bit sum to 8 bits. Results are delivered over a valid/ready stream with full throughput under backpressure, and entries whose sum carried out of 8 bits are counted.

---
 rtl/sum_readout_if.sv | 10 +
 rtl/sum_readout.sv | 149 ++++++++++++++
 tb/tb_sum_readout.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_readout_if.sv
// Pixel stream between sum_readout (master) and its downstream consumer (slave).
interface sum_readout_if;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_last;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/sum_readout.sv
// Sweeps the adder's 64-entry sum memory and streams normalised 8-bit pixels with overflow count.
// Build option: define SUM_SATURATE_EN for saturating normalisation, otherwise sums are halved.
module sum_readout #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W:0]   ovf_cnt,
  sum_readout_if.master     pix
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   ovf_r;
  logic              rd_vld_r;
  logic              rd_last_r;
  logic [7:0]        fifo_data_r [2];
  logic [1:0]        fifo_last_r;
  logic              wr_idx_r;
  logic              rd_idx_r;
  logic [1:0]        cnt_r;

  logic              valid_s;
  logic              head_last_s;
  logic              push_s;
  logic              pop_s;
  logic              issue_s;
  logic [2:0]        occ_s;
  logic [7:0]        norm_s;

  function automatic logic [7:0] normalise(input logic [DATA_W-1:0] sum);
`ifdef SUM_SATURATE_EN
    normalise = (|sum[DATA_W-1:8]) ? 8'hFF : sum[7:0];
`else
    normalise = sum[DATA_W-1:DATA_W-8];
`endif
  endfunction

  // The issue check counts the slot freed by this cycle's pop, so a stalled
  // consumer can never receive more data than the 2-entry buffer holds.
  assign valid_s     = (cnt_r != 2'd0);
  assign head_last_s = fifo_last_r[rd_idx_r];
  assign pop_s       = valid_s && pix.pix_ready;
  assign push_s      = rd_vld_r;
  assign occ_s       = {1'b0, cnt_r} - {2'b00, pop_s} + {2'b00, rd_vld_r};
  assign issue_s     = (state_r == RUN) && (occ_s < 3'd2);
  assign norm_s      = normalise(mem_dout);

  assign busy          = busy_r;
  assign done          = done_r;
  assign mem_en        = issue_s;
  assign mem_addr      = ptr_r;
  assign ovf_cnt       = ovf_r;
  assign pix.pix_valid = valid_s;
  assign pix.pix_data  = fifo_data_r[rd_idx_r];
  assign pix.pix_last  = head_last_s;

  // Frame control FSM with busy/done flags, read pointer and overflow counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ptr_r   <= '0;
      ovf_r   <= '0;
    end else begin
      done_r <= 1'b0;
      if (push_s && mem_dout[DATA_W-1]) begin
        ovf_r <= ovf_r + (ADDR_W+1)'(1'b1);
      end
      case (state_r)
        IDLE: begin
          // A start landing in the done cycle is still treated as busy.
          if (start && !done_r) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            ptr_r   <= '0;
            ovf_r   <= '0;
          end
        end
        RUN: begin
          if (issue_s) begin
            if (ptr_r == LAST_ADDR) begin
              state_r <= DRAIN;
            end else begin
              ptr_r <= ptr_r + ADDR_W'(1'b1);
            end
          end
        end
        DRAIN: begin
          if (pop_s && head_last_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return pipeline and the 2-entry output buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_r       <= 1'b0;
      rd_last_r      <= 1'b0;
      wr_idx_r       <= 1'b0;
      rd_idx_r       <= 1'b0;
      cnt_r          <= 2'd0;
      fifo_data_r[0] <= 8'd0;
      fifo_data_r[1] <= 8'd0;
      fifo_last_r    <= 2'b00;
    end else begin
      rd_vld_r  <= issue_s;
      rd_last_r <= issue_s && (ptr_r == LAST_ADDR);
      if (push_s) begin
        fifo_data_r[wr_idx_r] <= norm_s;
        fifo_last_r[wr_idx_r] <= rd_last_r;
        wr_idx_r              <= ~wr_idx_r;
      end
      if (pop_s) begin
        rd_idx_r <= ~rd_idx_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_readout.sv
// Randomised scoreboard bench for sum_readout: frames are predicted from the memory contents
// and a monitor checks every presented beat, the read address sequence and outstanding reads.
module tb_sum_readout;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, mem_en;
  logic [5:0] mem_addr;
  logic [8:0] mem_dout = 9'd0;
  logic [6:0] ovf_cnt;

  sum_readout_if pif();

  sum_readout dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .ovf_cnt(ovf_cnt), .pix(pif)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [64];
  exp_t       exp_q [$];
  int tests = 0, fails = 0;
  int cyc = 0;
  int exp_addr = 0, exp_ovf = 0;
  int issued = 0, accepted = 0;
  int beats = 0, done_count = 0;
  int start_cyc = 0, first_valid_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0;
  bit got_first = 1'b0;

  // Result memory model: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem_dout <= mem[mem_addr];
  end

  function automatic logic [7:0] exp_pix(input int sum);
`ifdef SUM_SATURATE_EN
    return (sum > 255) ? 8'd255 : 8'(sum);
`else
    return 8'(sum / 2);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares the presented beat with the scoreboard head every cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (pif.pix_valid) begin
        if (!got_first) begin
          got_first = 1'b1;
          first_valid_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {23'd0, pif.pix_data, pif.pix_last}, 32'hFFFFFFFF);
        end else begin
          check("beat", {23'd0, pif.pix_data, pif.pix_last}, {23'd0, exp_q[0].d, exp_q[0].l});
          if (pif.pix_ready) begin
            void'(exp_q.pop_front());
            if (beats == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            beats++;
          end
        end
      end
      if (mem_en) begin
        check("mem_addr", {26'd0, mem_addr}, exp_addr);
        exp_addr++;
      end
      issued   += int'(mem_en);
      accepted += int'(pif.pix_valid && pif.pix_ready);
      if (issued - accepted > 2) check("outstanding", issued - accepted, 2);
      if (done) begin
        done_count++;
        check("busy_at_done", {31'd0, busy}, 0);
      end
    end
  end

  task automatic launch_frame();
    exp_ovf = 0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{exp_pix(int'(mem[i])), (i == 63)});
      exp_ovf += int'(mem[i] >= 9'd256);
    end
    exp_addr  = 0;
    beats     = 0;
    got_first = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_ready);
    int n = 0;
    while (!done && n < 3000) begin
      if (rnd_ready) pif.pix_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    pif.pix_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {busy, done, mem_en, mem_addr, pif.pix_data, pif.pix_valid, pif.pix_last, ovf_cnt}, 32'd0);
  endtask

  initial begin
    int dc;
    pif.pix_ready = 1'b1;
    #12;
    check_idle_outputs("reset_values");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Frame A: ramp, always ready; latency and throughput.
    for (int i = 0; i < 64; i++) mem[i] = 9'(i * 4);
    launch_frame();
    wait_done(1'b0);
    check("done_latency", cyc - start_cyc + 1, 67);
    check("first_valid_latency", first_valid_cyc - start_cyc + 1, 3);
    check("back_to_back", last_hs_cyc - first_hs_cyc, 63);
    check("ovf_ramp", {25'd0, ovf_cnt}, exp_ovf);
    check("beats_ramp", beats, 64);
    @(posedge clk); #1;

    // Frame B: every sum carries.
    for (int i = 0; i < 64; i++) mem[i] = 9'h1FE;
    launch_frame();
    wait_done(1'b0);
    check("ovf_all", {25'd0, ovf_cnt}, 64);
    @(posedge clk); #1;

    // Frame C: identity data under random backpressure.
    for (int i = 0; i < 64; i++) mem[i] = 9'(i);
    launch_frame();
    wait_done(1'b1);
    check("beats_stall", beats, 64);
    check("ovf_stall", {25'd0, ovf_cnt}, 0);
    @(posedge clk); #1;

    // Frame D: random data, start re-pulsed mid-frame and in the done cycle.
    for (int i = 0; i < 64; i++) mem[i] = 9'($urandom_range(0, 511));
    launch_frame();
    dc = done_count;
    for (int n = 0; n < 3000 && beats < 10; n++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_second_frame_busy", {31'd0, busy}, 0);
    check("no_second_frame_issue", issued, accepted);
    check("single_done", done_count - dc, 1);
    check("ovf_random", {25'd0, ovf_cnt}, exp_ovf);

    // Frame E: reset during beat 20, then restart with the carry-boundary pattern.
    for (int i = 0; i < 64; i++) mem[i] = 9'($urandom_range(256, 511));
    launch_frame();
    for (int n = 0; n < 3000 && beats < 20; n++) begin
      @(posedge clk); #1;
    end
    dc = done_count;
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_mid_frame");
    exp_q.delete();
    issued = 0;
    accepted = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("no_done_on_reset", done_count - dc, 0);
    for (int i = 0; i < 64; i++) mem[i] = 9'd0;
    mem[5] = 9'h100;
    mem[6] = 9'h0FF;
    launch_frame();
    wait_done(1'b0);
    check("ovf_boundary", {25'd0, ovf_cnt}, 1);
    check("beats_restart", beats, 64);
    @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
